// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN                = 32;
    localparam int unsigned DEF_MAX_DATA_STREAK = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 16;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_D  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_valid;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [XLEN-1:0] d_rdata;
    logic            d_done;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    logic            stall_if;
    logic            stall_d;
    logic            bus_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_d, bus_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_d, bus_err
    );

endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// Clear/enable counter that flags the last allowed cycle of a bounded wait.
module mem_port_arbiter_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned         STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_t          r_state;
    logic [STREAK_W-1:0] r_streak;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [XLEN-1:0]     r_mem_addr;
    logic [XLEN-1:0]     r_mem_wdata;
    logic [XLEN-1:0]     r_if_rdata;
    logic [XLEN-1:0]     r_d_rdata;
    logic                r_if_valid;
    logic                r_d_done;
    logic                r_bus_err;

    logic w_if_live;
    logic w_d_live;
    logic w_busy;
    logic w_grant_d;
    logic w_grant_if;
    logic w_expire;

    // A requester whose completion pulse is high this cycle is still holding its old request.
    assign w_if_live  = bus.if_req & ~r_if_valid;
    assign w_d_live   = bus.d_req & ~r_d_done;
    assign w_busy     = (r_state != ARB_IDLE);
    assign w_grant_d  = ~w_busy & w_d_live & ((r_streak < STREAK_MAX) | ~w_if_live);
    assign w_grant_if = ~w_busy & w_if_live & ~w_grant_d;

    mem_port_arbiter_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (~w_busy),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ARB_IDLE;
            r_streak    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_done    <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_done   <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= ARB_BUSY_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.d_we;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                    end else if (w_grant_if) begin
                        r_state    <= ARB_BUSY_IF;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= bus.if_addr;
                    end
                    if (w_grant_if || !bus.if_req) begin
                        r_streak <= '0;
                    end else if (w_grant_d && (r_streak < STREAK_MAX)) begin
                        r_streak <= r_streak + 1'b1;
                    end
                end
                ARB_BUSY_IF: begin
                    if (bus.mem_ack || w_expire) begin
                        r_state    <= ARB_IDLE;
                        r_mem_req  <= 1'b0;
                        r_if_valid <= 1'b1;
                        if (bus.mem_ack) begin
                            r_if_rdata <= bus.mem_rdata;
                        end else begin
                            r_bus_err <= 1'b1;
                        end
                    end
                end
                ARB_BUSY_D: begin
                    if (bus.mem_ack || w_expire) begin
                        r_state   <= ARB_IDLE;
                        r_mem_req <= 1'b0;
                        r_d_done  <= 1'b1;
                        if (!bus.mem_ack) begin
                            r_bus_err <= 1'b1;
                        end else if (!r_mem_we) begin
                            r_d_rdata <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_done    = r_d_done;
    assign bus.bus_err   = r_bus_err;
    assign bus.stall_if  = bus.if_req & ~r_if_valid;
    assign bus.stall_d   = bus.d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned MAXS = 2;
    localparam int unsigned TMO  = 16;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MAX_DATA_STREAK (MAXS),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the port, for how long, and what each output must show.
    int          m_owner;   // 0 = nobody, 1 = fetch, 2 = data
    int          m_age;
    int          m_streak;
    logic        m_if_wait, m_d_wait;
    logic        e_mem_req, e_mem_we, e_if_valid, e_d_done, e_bus_err;
    logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = 0; m_age = 0; m_streak = 0;
            e_mem_req = 0; e_mem_we = 0; e_if_valid = 0; e_d_done = 0; e_bus_err = 0;
            e_mem_addr = 0; e_mem_wdata = 0; e_if_rdata = 0; e_d_rdata = 0;
        end else if (m_owner == 0) begin
            m_if_wait  = bus.if_req && !e_if_valid;
            m_d_wait   = bus.d_req && !e_d_done;
            e_if_valid = 0;
            e_d_done   = 0;
            m_age      = 0;
            if (m_d_wait && (m_streak < MAXS || !m_if_wait)) begin
                m_owner = 2; e_mem_req = 1; e_mem_we = bus.d_we;
                e_mem_addr = bus.d_addr; e_mem_wdata = bus.d_wdata;
                m_streak = !bus.if_req ? 0 : (m_streak < MAXS ? m_streak + 1 : m_streak);
            end else if (m_if_wait) begin
                m_owner = 1; e_mem_req = 1; e_mem_we = 0; e_mem_addr = bus.if_addr;
                m_streak = 0;
            end else if (!bus.if_req) begin
                m_streak = 0;
            end
        end else begin
            if (bus.mem_ack || m_age == TMO - 1) begin
                if (!bus.mem_ack) e_bus_err = 1;
                else if (m_owner == 1) e_if_rdata = bus.mem_rdata;
                else if (!e_mem_we) e_d_rdata = bus.mem_rdata;
                if (m_owner == 1) e_if_valid = 1;
                else e_d_done = 1;
                e_mem_req = 0;
                m_owner   = 0;
            end else begin
                m_age++;
            end
        end
    end

    task automatic quiet_inputs();
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        quiet_inputs();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.d_done, bus.bus_err, bus.stall_if, bus.stall_d} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 0000000", {bus.mem_req, bus.mem_we, bus.if_valid, bus.d_done, bus.bus_err, bus.stall_if, bus.stall_d});
        end
        tests_run++;
        if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 128'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h, expected 0", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_idle: mem_req got %b, expected 0", bus.mem_req); end
    endtask

    task automatic test_if_fetch();
        bus.if_req = 1; bus.if_addr = 32'h10; bus.mem_ack = 1; bus.mem_rdata = 32'h0050_0093;
        #1;
        tests_run++;
        if (bus.stall_if !== 1'b1) begin tests_failed++; $display("FAIL if_stall_c0: got %b, expected 1", bus.stall_if); end
        @(negedge clk);
        tests_run++;
        if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.stall_if} !== 4'b1001 || bus.mem_addr !== 32'h10) begin
            tests_failed++;
            $display("FAIL if_grant_c1: req/we/valid/stall got %b addr %h, expected 1001 addr 00000010", {bus.mem_req, bus.mem_we, bus.if_valid, bus.stall_if}, bus.mem_addr);
        end
        @(negedge clk);
        tests_run++;
        if ({bus.mem_req, bus.if_valid, bus.stall_if} !== 3'b010 || bus.if_rdata !== 32'h0050_0093) begin
            tests_failed++;
            $display("FAIL if_valid_c2: req/valid/stall got %b rdata %h, expected 010 rdata 00500093", {bus.mem_req, bus.if_valid, bus.stall_if}, bus.if_rdata);
        end
        @(negedge clk);
        tests_run++;
        if ({bus.mem_req, bus.if_valid} !== 2'b00 || bus.if_rdata !== 32'h0050_0093) begin
            tests_failed++;
            $display("FAIL if_no_regrant_c3: req/valid got %b rdata %h, expected 00 rdata 00500093", {bus.mem_req, bus.if_valid}, bus.if_rdata);
        end
        quiet_inputs();
        @(negedge clk);
    endtask

    task automatic test_store_then_fetch();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
        bus.if_req = 1; bus.if_addr = 32'h14; bus.mem_ack = 1; bus.mem_rdata = 32'h1111_1111;
        @(negedge clk);
        tests_run++;
        if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL st_data_first: req/we %b addr %h wdata %h, expected 11 addr 00000040 wdata deadbeef", {bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        tests_run++;
        if ({bus.d_done, bus.mem_req, bus.stall_d, bus.stall_if} !== 4'b1001 || bus.d_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL st_done: done/req/stall_d/stall_if %b d_rdata %h, expected 1001 d_rdata 00000000", {bus.d_done, bus.mem_req, bus.stall_d, bus.stall_if}, bus.d_rdata);
        end
        bus.d_req = 0;
        @(negedge clk);
        tests_run++;
        if ({bus.mem_req, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'h14) begin
            tests_failed++;
            $display("FAIL st_if_after: req/we %b addr %h, expected 10 addr 00000014", {bus.mem_req, bus.mem_we}, bus.mem_addr);
        end
        @(negedge clk);
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h1111_1111 || bus.d_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL st_if_valid: valid %b if_rdata %h d_rdata %h, expected 1 11111111 00000000", bus.if_valid, bus.if_rdata, bus.d_rdata);
        end
        quiet_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int   d_run = 0, n_if = 0, n_d = 0, first = 0, k_if = 0, k_d = 0;
        logic prev_req = 1'b0;
        bus.if_req = 1; bus.if_addr = 32'h1000; bus.d_req = 1; bus.d_we = 0;
        bus.d_addr = 32'h2000; bus.mem_ack = 1; bus.mem_rdata = 32'h0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.mem_req && !prev_req) begin
                if (bus.mem_addr[13:12] == 2'd2) begin
                    n_d++; d_run++;
                    if (first == 0) first = 2;
                    tests_run++;
                    if (d_run > MAXS) begin tests_failed++; $display("FAIL b2b_streak: data run %0d, expected at most %0d", d_run, MAXS); end
                end else begin
                    n_if++; d_run = 0;
                    if (first == 0) first = 1;
                end
            end
            prev_req = bus.mem_req;
            if (bus.if_valid) begin k_if++; bus.if_addr = 32'h1000 + 32'(4 * k_if); end
            if (bus.d_done) begin k_d++; bus.d_addr = 32'h2000 + 32'(4 * k_d); end
        end
        tests_run++;
        if (first != 2) begin tests_failed++; $display("FAIL b2b_first: first owner %0d, expected 2 (data)", first); end
        tests_run++;
        if (n_if < 1 || n_if * MAXS + MAXS < n_d || n_if + n_d < 10) begin
            tests_failed++;
            $display("FAIL b2b_share: if grants %0d data grants %0d, expected fetch served at least every %0d data grants", n_if, n_d, MAXS);
        end
        bus.if_req = 0; bus.d_req = 0;
        repeat (3) @(negedge clk);
        quiet_inputs();
        @(negedge clk);
    endtask

    task automatic test_delayed_load();
        int n_stall = 0, n_done = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h44; bus.mem_ack = 0;
        #1;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.stall_d === 1'b1) n_stall++;
            if (bus.d_done === 1'b1) n_done++;
            if (c == 5) begin bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678; end
            if (c == 6) begin
                tests_run++;
                if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h1234_5678) begin
                    tests_failed++;
                    $display("FAIL ld_done_c6: done %b d_rdata %h, expected 1 12345678", bus.d_done, bus.d_rdata);
                end
            end
        end
        tests_run++;
        if (n_stall != 6 || n_done != 1) begin
            tests_failed++;
            $display("FAIL ld_stall_len: stall cycles %0d done pulses %0d, expected 6 and 1", n_stall, n_done);
        end
        quiet_inputs();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int bad = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80; bus.mem_ack = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b1 || bus.d_done !== 1'b0 || bus.bus_err !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL to_busy_window: %0d bad cycles in 16 busy cycles, expected 0", bad); end
        @(negedge clk);
        tests_run++;
        if ({bus.d_done, bus.bus_err, bus.mem_req} !== 3'b110 || bus.d_rdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL to_abort_c17: done/err/req %b d_rdata %h, expected 110 12345678", {bus.d_done, bus.bus_err, bus.mem_req}, bus.d_rdata);
        end
        bus.d_req = 0; bus.mem_ack = 1; bus.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.mem_ack = 0;
        @(negedge clk);
        tests_run++;
        if ({bus.d_done, bus.bus_err, bus.mem_req} !== 3'b010 || bus.d_rdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL to_late_ack: done/err/req %b d_rdata %h, expected 010 12345678", {bus.d_done, bus.bus_err, bus.mem_req}, bus.d_rdata);
        end
        quiet_inputs();
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bus.if_req = 1; bus.if_addr = 32'h20; bus.mem_ack = 0;
        @(negedge clk);
        tests_run++;
        if (bus.mem_req !== 1'b1) begin tests_failed++; $display("FAIL ar_busy: mem_req got %b, expected 1", bus.mem_req); end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.d_done, bus.bus_err} !== 5'b0 ||
            {bus.mem_addr, bus.if_rdata, bus.d_rdata} !== 96'b0) begin
            tests_failed++;
            $display("FAIL ar_clear: flags %b data %h, expected all zero", {bus.mem_req, bus.mem_we, bus.if_valid, bus.d_done, bus.bus_err}, {bus.mem_addr, bus.if_rdata, bus.d_rdata});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20) begin
            tests_failed++;
            $display("FAIL ar_regrant: mem_req %b addr %h, expected 1 00000020", bus.mem_req, bus.mem_addr);
        end
        bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hCAFE_0001) begin
            tests_failed++;
            $display("FAIL ar_complete: valid %b rdata %h, expected 1 cafe0001", bus.if_valid, bus.if_rdata);
        end
        quiet_inputs();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [6:0] exp_flags;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            exp_flags = {e_mem_req, e_mem_we, e_if_valid, e_d_done, e_bus_err, bus.if_req & ~e_if_valid, bus.d_req & ~e_d_done};
            tests_run++;
            if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.d_done, bus.bus_err, bus.stall_if, bus.stall_d} !== exp_flags) begin
                tests_failed++;
                $display("FAIL rnd_flags c%0d: req/we/valid/done/err/stall_if/stall_d got %b, expected %b", c,
                         {bus.mem_req, bus.mem_we, bus.if_valid, bus.d_done, bus.bus_err, bus.stall_if, bus.stall_d}, exp_flags);
            end
            tests_run++;
            if (bus.mem_addr !== e_mem_addr || (e_mem_req && e_mem_we && bus.mem_wdata !== e_mem_wdata)) begin
                tests_failed++;
                $display("FAIL rnd_mem c%0d: addr %h wdata %h, expected addr %h wdata %h", c, bus.mem_addr, bus.mem_wdata, e_mem_addr, e_mem_wdata);
            end
            tests_run++;
            if (bus.if_rdata !== e_if_rdata || bus.d_rdata !== e_d_rdata) begin
                tests_failed++;
                $display("FAIL rnd_rdata c%0d: if %h d %h, expected if %h d %h", c, bus.if_rdata, bus.d_rdata, e_if_rdata, e_d_rdata);
            end
            if (!bus.if_req || bus.if_valid) begin
                bus.if_req  = ($urandom_range(0, 2) != 0);
                bus.if_addr = $urandom;
            end
            if (!bus.d_req || bus.d_done) begin
                bus.d_req   = ($urandom_range(0, 2) != 0);
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
            end
            bus.mem_ack   = ((c / 100) % 2 == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0);
            bus.mem_rdata = $urandom;
        end
        quiet_inputs();
        repeat (TMO + 2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_if_fetch();
        test_store_then_fetch();
        test_back_to_back();
        test_delayed_load();
        test_timeout();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
